// File: rtl/sram_port_arbiter_if.sv
// Shared SRAM-like port bundle: I and D requesters, the memory port and the error flag.
// The slave view belongs to the arbiter; the master view drives requesters and memory.
interface sram_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;
  logic        i_cancel;
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;
  logic        proto_err;

  modport slave (
    input  i_req, i_addr, i_cancel,
    input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    output i_addr_ok, i_data_ok, i_rdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output proto_err
  );

  modport master (
    output i_req, i_addr, i_cancel,
    output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    input  i_addr_ok, i_data_ok, i_rdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  proto_err
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between instruction and data requesters;
// an in-order owner FIFO steers each response, dropping flushed I replies.
module sram_port_arbiter #(
  parameter int MAX_OUT = 4
) (
  input logic               clk,
  input logic               resetn,
  sram_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          r_state;
  logic            r_own;
  logic            r_wr;
  logic [1:0]      r_size;
  logic [3:0]      r_wstrb;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_disc;
  logic            r_fown [MAX_OUT];
  logic            r_fdis [MAX_OUT];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;
  logic            r_perr;

  logic w_full;
  logic w_cap;
  logic w_push;
  logic w_pop;
  logic w_hown;
  logic w_hdis;

  assign w_full = (r_cnt == CW'(MAX_OUT));
  assign w_cap  = resetn && (r_state == IDLE) && !w_full;
  assign w_push = (r_state == HOLD) && bus.m_addr_ok;
  assign w_pop  = resetn && bus.m_data_ok && (r_cnt != '0);
  assign w_hown = r_fown[r_rp];
  assign w_hdis = r_fdis[r_rp];

  // D wins ties; an I request racing its own flush is refused
  assign bus.d_addr_ok = w_cap && bus.d_req;
  assign bus.i_addr_ok = w_cap && bus.i_req &&
                         !bus.d_req && !bus.i_cancel;

  assign bus.d_data_ok = w_pop && w_hown;
  assign bus.i_data_ok = w_pop && !w_hown &&
                         !w_hdis && !bus.i_cancel;
  assign bus.d_rdata   = bus.m_rdata;
  assign bus.i_rdata   = bus.m_rdata;

  assign bus.m_req     = (r_state == HOLD);
  assign bus.m_wr      = r_wr;
  assign bus.m_size    = r_size;
  assign bus.m_wstrb   = r_wstrb;
  assign bus.m_addr    = r_addr;
  assign bus.m_wdata   = r_wdata;
  assign bus.proto_err = r_perr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_own   <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_wstrb <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_disc  <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_perr  <= 1'b0;
      for (int k = 0; k < MAX_OUT; k++) begin
        r_fown[k] <= 1'b0;
        r_fdis[k] <= 1'b0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.d_addr_ok) begin
            r_state <= HOLD;
            r_own   <= 1'b1;
            r_wr    <= bus.d_wr;
            r_size  <= bus.d_size;
            r_wstrb <= bus.d_wstrb;
            r_addr  <= bus.d_addr;
            r_wdata <= bus.d_wdata;
            r_disc  <= 1'b0;
          end else if (bus.i_addr_ok) begin
            r_state <= HOLD;
            r_own   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd2;
            r_wstrb <= 4'd0;
            r_addr  <= bus.i_addr;
            r_wdata <= 32'd0;
            r_disc  <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.m_addr_ok)
            r_state <= IDLE;
          else if (bus.i_cancel && !r_own)
            r_disc <= 1'b1;
        end
      endcase

      if (bus.i_cancel) begin
        for (int k = 0; k < MAX_OUT; k++)
          if (!r_fown[k]) r_fdis[k] <= 1'b1;
      end

      // a held I request flushed on its issue cycle is still marked stale
      if (w_push) begin
        r_fown[r_wp] <= r_own;
        r_fdis[r_wp] <= r_disc | (bus.i_cancel & ~r_own);
        r_wp         <= r_wp + 1'b1;
      end

      if (w_pop)
        r_rp <= r_rp + 1'b1;

      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;

      if (bus.m_data_ok && (r_cnt == '0))
        r_perr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a response-order scoreboard.
module tb_sram_port_arbiter;
  logic clk;
  logic resetn;
  int   errs;
  int   checks;

  typedef struct packed {
    logic is_d;
    logic drop;
  } exp_t;

  exp_t q[$];

  sram_port_arbiter_if bus();

  sram_port_arbiter #(.MAX_OUT(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic d, input logic dr);
    exp_t e;
    e.is_d = d;
    e.drop = dr;
    return e;
  endfunction

  task automatic mark_cancel();
    foreach (q[k])
      if (!q[k].is_d) q[k].drop = 1'b1;
  endtask

  task automatic issue_i(input logic [31:0] a);
    bus.i_req  = 1'b1;
    bus.i_addr = a;
    #2;
    chk("i_addr_ok", bus.i_addr_ok, 1);
    tick();
    bus.i_req     = 1'b0;
    bus.m_addr_ok = 1'b1;
    q.push_back(mk(1'b0, 1'b0));
    #2;
    chk("i_m_req", bus.m_req, 1);
    chk("i_m_addr", bus.m_addr, a);
    tick();
    bus.m_addr_ok = 1'b0;
  endtask

  task automatic issue_d(input logic wr,
                         input logic [31:0] a,
                         input logic [31:0] wd);
    bus.d_req   = 1'b1;
    bus.d_wr    = wr;
    bus.d_size  = 2'd2;
    bus.d_wstrb = wr ? 4'hF : 4'h0;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    #2;
    chk("d_addr_ok", bus.d_addr_ok, 1);
    tick();
    bus.d_req     = 1'b0;
    bus.m_addr_ok = 1'b1;
    q.push_back(mk(1'b1, 1'b0));
    #2;
    chk("d_m_req", bus.m_req, 1);
    chk("d_m_addr", bus.m_addr, a);
    chk("d_m_wr", bus.m_wr, wr);
    chk("d_m_wdata", bus.m_wdata, wd);
    tick();
    bus.m_addr_ok = 1'b0;
  endtask

  task automatic resp(input logic [31:0] rd, input logic cx);
    exp_t e;
    bus.m_data_ok = 1'b1;
    bus.m_rdata   = rd;
    bus.i_cancel  = cx;
    if (cx) mark_cancel();
    #2;
    if (q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = q.pop_front();
      chk("d_data_ok", bus.d_data_ok, e.is_d);
      chk("i_data_ok", bus.i_data_ok, !e.is_d && !e.drop);
      if (e.is_d)
        chk("d_rdata", bus.d_rdata, rd);
      else if (!e.drop)
        chk("i_rdata", bus.i_rdata, rd);
    end
    tick();
    bus.m_data_ok = 1'b0;
    bus.i_cancel  = 1'b0;
  endtask

  task automatic cancel_pulse();
    bus.i_cancel = 1'b1;
    mark_cancel();
    #2;
    tick();
    bus.i_cancel = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    resetn = 1'b0;
    bus.i_req = 0; bus.i_addr = 0; bus.i_cancel = 0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_size = 0;
    bus.d_wstrb = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.m_addr_ok = 0; bus.m_data_ok = 0; bus.m_rdata = 0;
    #2;
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_d_aok", bus.d_addr_ok, 0);
    chk("rst_i_aok", bus.i_addr_ok, 0);
    chk("rst_perr", bus.proto_err, 0);
    tick();
    resetn = 1'b1;
    tick();

    // D and I together: D first, I waits for D issue
    bus.d_req = 1; bus.d_wr = 0; bus.d_size = 2'd2;
    bus.d_addr = 32'h1C00_0100;
    bus.i_req = 1; bus.i_addr = 32'h1C00_0000;
    #2;
    chk("pri_d_aok", bus.d_addr_ok, 1);
    chk("pri_i_aok", bus.i_addr_ok, 0);
    tick();
    bus.d_req = 0;
    #2;
    chk("hold_m_req", bus.m_req, 1);
    chk("hold_addr", bus.m_addr, 32'h1C00_0100);
    chk("hold_wr", bus.m_wr, 0);
    chk("hold_size", bus.m_size, 2);
    chk("hold_i_aok", bus.i_addr_ok, 0);
    tick();
    tick();
    tick();
    bus.m_addr_ok = 1;
    q.push_back(mk(1'b1, 1'b0));
    #2;
    chk("late_addr", bus.m_addr, 32'h1C00_0100);
    chk("late_i_aok", bus.i_addr_ok, 0);
    tick();
    bus.m_addr_ok = 0;
    #2;
    chk("gap_m_req", bus.m_req, 0);
    chk("after_i_aok", bus.i_addr_ok, 1);
    tick();
    bus.i_req = 0;
    bus.m_addr_ok = 1;
    q.push_back(mk(1'b0, 1'b0));
    #1;
    chk("i_hold_addr", bus.m_addr, 32'h1C00_0000);
    resp(32'hDEADBEEF, 1'b0);
    bus.m_addr_ok = 0;
    resp(32'h1111_1111, 1'b0);

    // fill to MAX_OUT, capture blocked until one response
    for (int k = 0; k < 4; k++)
      issue_i(32'h2000_0000 + 32'(k * 4));
    bus.i_req = 1; bus.i_addr = 32'h2000_0040;
    #2;
    chk("full_i_aok", bus.i_addr_ok, 0);
    chk("full_m_req", bus.m_req, 0);
    tick();
    resp(32'hA000_0000, 1'b0);
    #2;
    chk("resume_aok", bus.i_addr_ok, 1);
    tick();
    bus.i_req = 0;
    bus.m_addr_ok = 1;
    q.push_back(mk(1'b0, 1'b0));
    tick();
    bus.m_addr_ok = 0;
    for (int k = 1; k < 5; k++)
      resp(32'hA000_0000 + 32'(k), 1'b0);

    // flush two in-flight I reads
    issue_i(32'h3000_0000);
    issue_i(32'h3000_0004);
    cancel_pulse();
    resp(32'hB000_0001, 1'b0);
    resp(32'hB000_0002, 1'b0);
    issue_i(32'h3000_0008);
    resp(32'hB000_0003, 1'b0);

    // store behind a flushed I read still acks
    issue_i(32'h3100_0000);
    issue_d(1'b1, 32'h1C00_0200, 32'hCAFE_F00D);
    cancel_pulse();
    resp(32'hC000_0001, 1'b0);
    resp(32'hC000_0002, 1'b0);

    // flush coincident with the I response
    issue_i(32'h3200_0000);
    resp(32'hC100_0000, 1'b1);

    // I request and flush in the same cycle
    bus.i_req = 1; bus.i_cancel = 1; bus.i_addr = 32'h3300_0000;
    #2;
    chk("cx_i_aok", bus.i_addr_ok, 0);
    tick();
    bus.i_cancel = 0;
    #2;
    chk("cx_m_req", bus.m_req, 0);
    // flush while the I request sits in hold
    chk("hold_cx_aok", bus.i_addr_ok, 1);
    tick();
    bus.i_req = 0; bus.i_cancel = 1;
    #2;
    chk("hold_cx_req", bus.m_req, 1);
    tick();
    bus.i_cancel = 0;
    bus.m_addr_ok = 1;
    q.push_back(mk(1'b0, 1'b1));
    tick();
    bus.m_addr_ok = 0;
    resp(32'hC200_0000, 1'b0);

    // stray response with nothing outstanding
    bus.m_data_ok = 1; bus.m_rdata = 32'h5555_5555;
    #2;
    chk("stray_d_ok", bus.d_data_ok, 0);
    chk("stray_i_ok", bus.i_data_ok, 0);
    tick();
    bus.m_data_ok = 0;
    #2;
    chk("perr_set", bus.proto_err, 1);
    tick();
    tick();
    chk("perr_sticky", bus.proto_err, 1);

    // async reset in the middle of a held request
    for (int k = 0; k < 3; k++)
      issue_i(32'h4000_0000 + 32'(k * 4));
    bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h4400_0000;
    #2;
    chk("pre_rst_aok", bus.d_addr_ok, 1);
    tick();
    bus.d_req = 0;
    #2;
    chk("pre_rst_req", bus.m_req, 1);
    #1;
    resetn = 0;
    #1;
    chk("arst_m_req", bus.m_req, 0);
    chk("arst_perr", bus.proto_err, 0);
    q.delete();
    tick();
    resetn = 1;
    tick();
    for (int k = 0; k < 4; k++)
      issue_i(32'h5000_0000 + 32'(k * 4));
    bus.i_req = 1;
    #2;
    chk("rst_cnt_full", bus.i_addr_ok, 0);
    tick();
    bus.i_req = 0;
    for (int k = 0; k < 4; k++)
      resp(32'hE000_0000 + 32'(k), 1'b0);
    chk("sb_drained", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
